priority_dec_n: RTL and testbench
=================================

// Module: priority_dec_n
// PURPOSE
//  Decoder counterpart of the priority/count encoder: accepts a bit-count (0..WIDTH) over a
//  valid/ready stream and emits the matching WIDTH-bit thermometer mask and top-bit one-hot.
//  Buffered by a 2-entry skid queue so upstream and downstream handshakes decouple at full
//  throughput. Sits on the return path where counts from the encoder are re-expanded into masks.
// PARAMETERS
//  WIDTH   7   output vector width; legal counts 0..WIDTH
//  CW      clog2(WIDTH+1) (localparam, =3 at default); width of in_cnt
// PORTS
//  clk         in   1      single clock, all logic on posedge
//  rst         in   1      reset: synchronous, active-high
//  in_valid    in   1      in_cnt valid
//  in_ready    out  1      block can accept; transfer when in_valid && in_ready
//  in_cnt      in   CW     count to decode
//  out_valid   out  1      output entry valid
//  out_ready   in   1      downstream accepts; pop when out_valid && out_ready
//  out_therm   out  WIDTH  bits [n-1:0] set, rest clear (n = count, saturated)
//  out_onehot  out  WIDTH  only bit n-1 set; all zero when n=0
//  out_sat     out  1      this entry's in_cnt exceeded WIDTH
//  sat_sticky  out  1      set on any accepted saturating count; held until clr_sticky
//  clr_sticky  in   1      clears sat_sticky
// BEHAVIOUR
//  - Reset (rst=1 at posedge): occupancy->EMPTY, out_valid=0, out_therm=0, out_onehot=0,
//    out_sat=0, sat_sticky=0. in_ready=0 while rst high, 1 on first cycle after.
//  - Occupancy FSM: EMPTY -> ONE (push) ; ONE -> TWO (push, no pop) ; ONE -> EMPTY (pop, no push);
//    ONE stays ONE (push+pop: head replaced by new entry) ; TWO -> ONE (pop). No push possible in TWO.
//  - in_ready = (state != TWO) && !rst; comb from registered state only, never from out_ready.
//  - Latency: count accepted at edge N appears on outputs with out_valid=1 after edge N (cycle N+1)
//    when queue was empty; otherwise behind the older entry, strict FIFO order.
//  - Outputs are registered and stable while out_valid && !out_ready (no change, no glitch).
//  - Decode: n = (in_cnt > WIDTH) ? WIDTH : in_cnt; out_sat = (in_cnt > WIDTH). Decode occurs on
//    push; queue stores decoded therm + sat (onehot derived from stored therm: therm & ~(therm>>1)).
//  - sat_sticky: set on push of saturating entry; clr_sticky clears; set wins if same cycle.
//  - Unused queue entries hold last value; not observable (out_valid gates them).
//  - Reset mid-transfer discards both entries; no partial outputs after reset.
//  - in_cnt carrying X/Z while in_valid=1 is illegal; no X-propagation handling inside.
// STRUCTURE
//  - priority_pkg: clog2 function, CW derivation helper; shared with the encoder.
//  - Sub-module therm_dec_n (combinational): in_cnt -> {sat, therm[WIDTH-1:0]}.
//  - Top: 2-entry skid queue (head/tail regs + 2-bit state), sticky flag, onehot derivation.
// TESTING (WIDTH=7, CW=3)
//  1 Reset: rst high 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, all outputs 0.
//  2 in_cnt=3, out_ready=1 -> next cycle out_therm=7'b0000111, out_onehot=7'b0000100, out_sat=0.
//  3 in_cnt=0 then 7 -> therm 0/onehot 0, then therm 7'h7F/onehot 7'b1000000.
//  4 Backpressure: out_ready=0, push 1,2,5 -> third push stalls (in_ready=0 after 2); release ->
//    outputs 1,2,5 in order, therm 7'h01,7'h03,7'h1F, no loss or duplication.
//  5 Full-rate stream 0..7 repeating with out_ready=1 -> one output per cycle, in_ready stays 1.
//  6 CW=4 variant (WIDTH=8) in_cnt=12 -> therm 8'hFF, out_sat=1, sat_sticky=1; clr_sticky with
//    simultaneous saturating push -> sticky stays 1; clr alone -> 0.

Source files
------------

// File: rtl/priority_dec_n_pkg.sv
// Shared helpers for the priority encoder/decoder pair.
// Count-width derivation and queue occupancy encoding.
package priority_dec_n_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Width of a count that spans 0..width inclusive.
    function automatic int cw_of(input int width);
        return (width < 1) ? 1 : clog2(width + 1);
    endfunction

endpackage

// File: rtl/priority_dec_n_therm_dec_n.sv
// Combinational count-to-thermometer decoder.
// Counts above WIDTH saturate to an all-ones mask and raise sat.
module therm_dec_n
    import priority_dec_n_pkg::*;
#(
    parameter int WIDTH = 7,
    parameter int CW    = cw_of(WIDTH)
) (
    input  logic [CW-1:0]    cnt,
    output logic [WIDTH-1:0] therm,
    output logic             sat
);

    localparam logic [CW:0]      WMAX = WIDTH[CW:0];
    localparam logic [CW-1:0]    WSAT = WIDTH[CW-1:0];
    localparam logic [WIDTH-1:0] ONES = '1;

    logic [CW-1:0] n;

    always_comb begin
        sat   = ({1'b0, cnt} > WMAX);
        n     = sat ? WSAT : cnt;
        therm = ~(ONES << n);
    end

endmodule

// File: rtl/priority_dec_n.sv
// Count-to-mask decoder behind a 2-entry skid queue.
// Emits thermometer mask, top-bit one-hot and saturation flags.
module priority_dec_n
    import priority_dec_n_pkg::*;
#(
    parameter  int WIDTH = 7,
    localparam int CW    = cw_of(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CW-1:0]    in_cnt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_therm,
    output logic [WIDTH-1:0] out_onehot,
    output logic             out_sat,
    output logic             sat_sticky,
    input  logic             clr_sticky
);

    occ_e state, state_nx;

    logic [WIDTH-1:0] head_therm, tail_therm, dec_therm;
    logic             head_sat, tail_sat, dec_sat;
    logic             push, pop;
    logic             load_head, load_tail, head_from_tail;

    therm_dec_n #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_dec (
        .cnt   (in_cnt),
        .therm (dec_therm),
        .sat   (dec_sat)
    );

    assign in_ready   = (state != TWO) && !rst;
    assign out_valid  = (state != EMPTY);
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign out_therm  = head_therm;
    assign out_sat    = head_sat;
    assign out_onehot = head_therm & ~(head_therm >> 1);

    always_comb begin
        state_nx       = state;
        load_head      = 1'b0;
        load_tail      = 1'b0;
        head_from_tail = 1'b0;
        unique case (state)
            EMPTY: begin
                if (push) begin
                    state_nx  = ONE;
                    load_head = 1'b1;
                end
            end
            ONE: begin
                // Simultaneous push/pop replaces the head in place.
                if (push && pop) begin
                    load_head = 1'b1;
                end else if (push) begin
                    state_nx  = TWO;
                    load_tail = 1'b1;
                end else if (pop) begin
                    state_nx  = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    state_nx       = ONE;
                    head_from_tail = 1'b1;
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            head_therm <= '0;
            head_sat   <= 1'b0;
            tail_therm <= '0;
            tail_sat   <= 1'b0;
            sat_sticky <= 1'b0;
        end else begin
            state <= state_nx;
            if (load_head) begin
                head_therm <= dec_therm;
                head_sat   <= dec_sat;
            end else if (head_from_tail) begin
                head_therm <= tail_therm;
                head_sat   <= tail_sat;
            end
            if (load_tail) begin
                tail_therm <= dec_therm;
                tail_sat   <= dec_sat;
            end
            if (push && dec_sat) begin
                sat_sticky <= 1'b1;
            end else if (clr_sticky) begin
                sat_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_priority_dec_n.sv
// Directed bench for priority_dec_n at WIDTH=7 and WIDTH=8.
// WIDTH=7 outputs are checked against a queue of predicted entries.
module tb_priority_dec_n;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       v7_in_valid = 1'b0;
    logic       v7_in_ready;
    logic [2:0] v7_in_cnt = '0;
    logic       v7_out_valid;
    logic       v7_out_ready = 1'b0;
    logic [6:0] v7_therm, v7_onehot;
    logic       v7_sat, v7_sticky;
    logic       v7_clr = 1'b0;

    logic       v8_in_valid = 1'b0;
    logic       v8_in_ready;
    logic [3:0] v8_in_cnt = '0;
    logic       v8_out_valid;
    logic       v8_out_ready = 1'b1;
    logic [7:0] v8_therm, v8_onehot;
    logic       v8_sat, v8_sticky;
    logic       v8_clr = 1'b0;

    int checks = 0;
    int errors = 0;
    int pops7  = 0;
    int cyc    = 0;

    logic [14:0] sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    priority_dec_n #(.WIDTH(7)) u7 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (v7_in_valid),
        .in_ready   (v7_in_ready),
        .in_cnt     (v7_in_cnt),
        .out_valid  (v7_out_valid),
        .out_ready  (v7_out_ready),
        .out_therm  (v7_therm),
        .out_onehot (v7_onehot),
        .out_sat    (v7_sat),
        .sat_sticky (v7_sticky),
        .clr_sticky (v7_clr)
    );

    priority_dec_n #(.WIDTH(8)) u8 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (v8_in_valid),
        .in_ready   (v8_in_ready),
        .in_cnt     (v8_in_cnt),
        .out_valid  (v8_out_valid),
        .out_ready  (v8_out_ready),
        .out_therm  (v8_therm),
        .out_onehot (v8_onehot),
        .out_sat    (v8_sat),
        .sat_sticky (v8_sticky),
        .clr_sticky (v8_clr)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] model7(input int c);
        int n;
        logic [6:0] th, oh;
        n  = (c > 7) ? 7 : c;
        th = 7'((1 << n) - 1);
        oh = (n == 0) ? 7'd0 : 7'(1 << (n - 1));
        return {(c > 7), oh, th};
    endfunction

    // Scoreboard: pop/compare on output transfer, then record input transfer.
    always @(negedge clk) begin
        if (!rst) begin
            if (v7_out_valid && v7_out_ready) begin
                pops7++;
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    logic [14:0] e;
                    e = sb.pop_front();
                    check("w7_therm", {25'd0, v7_therm}, {25'd0, e[6:0]});
                    check("w7_onehot", {25'd0, v7_onehot}, {25'd0, e[13:7]});
                    check("w7_sat", {31'd0, v7_sat}, {31'd0, e[14]});
                end
            end
            if (v7_in_valid && v7_in_ready) sb.push_back(model7(int'(v7_in_cnt)));
        end
    end

    task automatic push7(input int c);
        int t;
        t = 0;
        v7_in_valid = 1'b1;
        v7_in_cnt   = 3'(c);
        @(negedge clk);
        while (!v7_in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("push7_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        v7_in_valid = 1'b0;
    endtask

    task automatic push8(input int c);
        int t;
        t = 0;
        v8_in_valid = 1'b1;
        v8_in_cnt   = 4'(c);
        @(negedge clk);
        while (!v8_in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("push8_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        v8_in_valid = 1'b0;
    endtask

    initial begin
        int c0;

        // Reset held with valid asserted.
        v7_in_valid = 1'b1;
        v7_in_cnt   = 3'd5;
        repeat (2) begin
            @(negedge clk);
            check("rst_in_ready", {31'd0, v7_in_ready}, 32'd0);
            check("rst_out_valid", {31'd0, v7_out_valid}, 32'd0);
        end
        check("rst_therm", {25'd0, v7_therm}, 32'd0);
        check("rst_onehot", {25'd0, v7_onehot}, 32'd0);
        check("rst_sat", {31'd0, v7_sat}, 32'd0);
        check("rst_sticky", {31'd0, v7_sticky}, 32'd0);
        check("rst_sticky8", {31'd0, v8_sticky}, 32'd0);
        @(posedge clk);
        #1;
        rst         = 1'b0;
        v7_in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {31'd0, v7_in_ready}, 32'd1);
        check("post_rst_valid", {31'd0, v7_out_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Single count, one-cycle latency.
        v7_out_ready = 1'b1;
        push7(3);
        @(negedge clk);
        check("lat_valid", {31'd0, v7_out_valid}, 32'd1);
        check("lat_therm", {25'd0, v7_therm}, 32'h07);
        @(posedge clk);
        #1;

        // Boundary counts.
        push7(0);
        push7(7);
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: third push stalls while queue is full.
        v7_out_ready = 1'b0;
        push7(1);
        push7(2);
        v7_in_valid = 1'b1;
        v7_in_cnt   = 3'd5;
        @(negedge clk);
        check("full_in_ready", {31'd0, v7_in_ready}, 32'd0);
        check("hold_therm_a", {25'd0, v7_therm}, 32'h01);
        @(negedge clk);
        check("full_in_ready2", {31'd0, v7_in_ready}, 32'd0);
        check("hold_therm_b", {25'd0, v7_therm}, 32'h01);
        check("hold_valid", {31'd0, v7_out_valid}, 32'd1);
        @(posedge clk);
        #1;
        v7_out_ready = 1'b1;
        push7(5);
        repeat (4) @(posedge clk);
        #1;
        check("bp_drained", {31'd0, v7_out_valid}, 32'd0);

        // Full-rate stream.
        c0 = cyc;
        for (int i = 0; i < 16; i++) push7(i % 8);
        check("stream_cycles", 32'(cyc - c0), 32'd16);
        repeat (4) @(posedge clk);
        #1;
        check("pops7", 32'(pops7), 32'd22);
        check("sb_empty", 32'(sb.size()), 32'd0);

        // WIDTH=8: saturation and sticky behaviour.
        push8(12);
        @(negedge clk);
        check("w8_therm", {24'd0, v8_therm}, 32'hFF);
        check("w8_onehot", {24'd0, v8_onehot}, 32'h80);
        check("w8_sat", {31'd0, v8_sat}, 32'd1);
        check("w8_sticky", {31'd0, v8_sticky}, 32'd1);
        @(posedge clk);
        #1;
        v8_clr = 1'b1;
        push8(9);
        v8_clr = 1'b0;
        @(negedge clk);
        check("w8_set_wins", {31'd0, v8_sticky}, 32'd1);
        @(posedge clk);
        #1;
        push8(4);
        @(negedge clk);
        check("w8_therm4", {24'd0, v8_therm}, 32'h0F);
        check("w8_sat4", {31'd0, v8_sat}, 32'd0);
        check("w8_sticky_hold", {31'd0, v8_sticky}, 32'd1);
        @(posedge clk);
        #1;
        v8_clr = 1'b1;
        @(posedge clk);
        #1;
        v8_clr = 1'b0;
        @(negedge clk);
        check("w8_clr", {31'd0, v8_sticky}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
